// File: rtl/sigma_delta_pkg.sv
// Shared sizing helpers for the sigma-delta CIC decimator, its harness and its bench.
package sigma_delta_pkg;

  // Bit growth of an N-stage CIC with decimation R, plus sign and full-scale headroom.
  function automatic int cic_width(input int stages, input int osr);
    return 2 + stages * $clog2(osr);
  endfunction

  // Half of the full-scale gain R^N; the zero point of the bipolar output.
  function automatic longint cic_midscale(input int stages, input int osr);
    longint gain;
    gain = 1;
    for (int i = 0; i < stages; i++) begin
      gain = gain * longint'(osr);
    end
    return gain / 2;
  endfunction

endpackage

// File: rtl/sigma_delta_cic_comb_stage.sv
// One CIC differentiator at the decimated rate: y = x - x_delayed, advanced by its token.
module sigma_delta_cic_comb_stage #(
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] x_in,
  output logic              vld_out,
  output logic [DATA_W-1:0] y_out
);

  logic [DATA_W-1:0] x_dly;

  // Delay and result only move when a decimated sample passes through.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_out <= 1'b0;
      y_out   <= '0;
      x_dly   <= '0;
    end else begin
      vld_out <= vld_in;
      if (vld_in) begin
        y_out <= x_in - x_dly;
        x_dly <= x_in;
      end
    end
  end

endmodule

// File: rtl/sigma_delta_cic_decimator.sv
// Hogenauer CIC decimator: PDM bit stream in, one PCM word per OVERSAMPLE_RATE clocks out.
module sigma_delta_cic_decimator
  import sigma_delta_pkg::*;
#(
  parameter int OVERSAMPLE_RATE = 256,
  parameter int CIC_STAGES      = 2,
  parameter int ADC_BITLEN      = 18,
  parameter int SIGNED_OUTPUT   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pdm_in,
  output logic [ADC_BITLEN-1:0] adc_output,
  output logic                  adc_valid
);

  localparam int CNT_W = $clog2(OVERSAMPLE_RATE);
  localparam logic [ADC_BITLEN-1:0] MIDSCALE = (SIGNED_OUTPUT != 0) ?
    ADC_BITLEN'(cic_midscale(CIC_STAGES, OVERSAMPLE_RATE)) : '0;

  if (OVERSAMPLE_RATE < 4 || (OVERSAMPLE_RATE & (OVERSAMPLE_RATE - 1)) != 0) begin : g_bad_osr
    $error("OVERSAMPLE_RATE must be a power of two >= 4");
  end
  if (CIC_STAGES < 1 || CIC_STAGES > 5 || CIC_STAGES > OVERSAMPLE_RATE - 2) begin : g_bad_stages
    $error("CIC_STAGES must be 1..5 and no more than OVERSAMPLE_RATE-2");
  end
  if (ADC_BITLEN < cic_width(CIC_STAGES, OVERSAMPLE_RATE)) begin : g_bad_width
    $error("ADC_BITLEN too small for CIC bit growth");
  end

  logic [ADC_BITLEN-1:0] integ     [CIC_STAGES];
  logic [ADC_BITLEN-1:0] integ_nxt [CIC_STAGES];
  logic [CNT_W-1:0]      dec_cnt;
  logic                  strobe;
  logic [ADC_BITLEN-1:0] cap_p0;
  logic                  vld_p0;
  logic [ADC_BITLEN-1:0] comb_x [CIC_STAGES+1];
  logic [CIC_STAGES:0]   comb_vld;

  assign strobe = &dec_cnt;

  // Integrators wrap freely; the comb differences undo the wrap exactly.
  always_comb begin
    integ_nxt[0] = integ[0] + ADC_BITLEN'(pdm_in);
    for (int k = 1; k < CIC_STAGES; k++) begin
      integ_nxt[k] = integ[k] + integ[k-1];
    end
  end

  // Stage p0: integrate every clock, capture the last integrator on the strobe edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CIC_STAGES; k++) begin
        integ[k] <= '0;
      end
      dec_cnt <= '0;
      cap_p0  <= '0;
      vld_p0  <= 1'b0;
    end else begin
      for (int k = 0; k < CIC_STAGES; k++) begin
        integ[k] <= integ_nxt[k];
      end
      dec_cnt <= dec_cnt + CNT_W'(1);
      vld_p0  <= strobe;
      if (strobe) begin
        cap_p0 <= integ_nxt[CIC_STAGES-1];
      end
    end
  end

  assign comb_x[0]   = cap_p0;
  assign comb_vld[0] = vld_p0;

  for (genvar i = 0; i < CIC_STAGES; i++) begin : g_comb
    sigma_delta_cic_comb_stage #(
      .DATA_W (ADC_BITLEN)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .vld_in  (comb_vld[i]),
      .x_in    (comb_x[i]),
      .vld_out (comb_vld[i+1]),
      .y_out   (comb_x[i+1])
    );
  end

  // Output stage: register the final difference when its token leaves the comb chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      adc_valid  <= 1'b0;
      adc_output <= '0;
    end else begin
      adc_valid <= comb_vld[CIC_STAGES];
      if (comb_vld[CIC_STAGES]) begin
        adc_output <= comb_x[CIC_STAGES] - MIDSCALE;
      end
    end
  end

endmodule

// File: tb/tb_sigma_delta_cic_decimator.sv
// Scoreboard bench for the CIC decimator: three configurations driven by one PDM stream.
module tb_sigma_delta_cic_decimator;

  localparam int ND = 3;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        pdm_in = 1'b0;
  logic [17:0] out0, out1;
  logic [19:0] out2;
  logic        vld0, vld1, vld2;

  always #5 clk = ~clk;

  sigma_delta_cic_decimator #(
    .OVERSAMPLE_RATE(256), .CIC_STAGES(2), .ADC_BITLEN(18), .SIGNED_OUTPUT(0)
  ) dut_u (
    .clk(clk), .rst(rst), .pdm_in(pdm_in), .adc_output(out0), .adc_valid(vld0)
  );

  sigma_delta_cic_decimator #(
    .OVERSAMPLE_RATE(256), .CIC_STAGES(2), .ADC_BITLEN(18), .SIGNED_OUTPUT(1)
  ) dut_s (
    .clk(clk), .rst(rst), .pdm_in(pdm_in), .adc_output(out1), .adc_valid(vld1)
  );

  sigma_delta_cic_decimator #(
    .OVERSAMPLE_RATE(64), .CIC_STAGES(3), .ADC_BITLEN(20), .SIGNED_OUTPUT(0)
  ) dut_w (
    .clk(clk), .rst(rst), .pdm_in(pdm_in), .adc_output(out2), .adc_valid(vld2)
  );

  typedef struct {
    longint val;
    int     due;
  } exp_t;

  exp_t   q0[$], q1[$], q2[$];
  longint integ [ND][5];
  longint hist  [ND][6];
  longint last_out [ND];
  int     first_edge [ND];
  int     ecnt      = 0;
  bit     rst_seen  = 1'b1;
  int     n_checks  = 0;
  int     n_fail    = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int r_of(input int id);
    return (id == 2) ? 64 : 256;
  endfunction
  function automatic int n_of(input int id);
    return (id == 2) ? 3 : 2;
  endfunction
  function automatic longint mask_of(input int id);
    return (id == 2) ? 64'h000F_FFFF : 64'h0003_FFFF;
  endfunction
  function automatic longint mid_of(input int id);
    return (id == 1) ? 64'd32768 : 64'd0;
  endfunction

  function automatic longint out_of(input int id);
    case (id)
      0:       return longint'(out0);
      1:       return longint'(out1);
      default: return longint'(out2);
    endcase
  endfunction
  function automatic bit valid_of(input int id);
    case (id)
      0:       return vld0;
      1:       return vld1;
      default: return vld2;
    endcase
  endfunction

  task automatic q_push(input int id, input exp_t e);
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask
  function automatic int q_len(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction
  function automatic int q_due(input int id);
    case (id)
      0:       return q0[0].due;
      1:       return q1[0].due;
      default: return q2[0].due;
    endcase
  endfunction
  task automatic q_pop(input int id, output exp_t e);
    case (id)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  // Predicts the effect of the coming rising edge given the inputs being applied now.
  task automatic model_step(input bit p, input bit r);
    longint acc, c;
    int     n;
    exp_t   e;
    if (r) begin
      ecnt     = 0;
      rst_seen = 1'b1;
      q0.delete(); q1.delete(); q2.delete();
      for (int id = 0; id < ND; id++) begin
        for (int k = 0; k < 5; k++) integ[id][k] = 0;
        for (int j = 0; j < 6; j++) hist[id][j] = 0;
      end
      return;
    end
    for (int id = 0; id < ND; id++) begin
      n = n_of(id);
      for (int k = n - 1; k >= 1; k--) begin
        integ[id][k] = (integ[id][k] + integ[id][k-1]) & mask_of(id);
      end
      integ[id][0] = (integ[id][0] + longint'(p)) & mask_of(id);
      if (ecnt % r_of(id) == r_of(id) - 1) begin
        for (int j = 5; j >= 1; j--) hist[id][j] = hist[id][j-1];
        hist[id][0] = integ[id][n-1];
        // N-th order backward difference of the captured sequence, binomial weights.
        acc = 0;
        c   = 1;
        for (int j = 0; j <= n; j++) begin
          acc = (j % 2 == 1) ? acc - c * hist[id][j] : acc + c * hist[id][j];
          c   = c * longint'(n - j) / longint'(j + 1);
        end
        e.val = (acc - mid_of(id)) & mask_of(id);
        e.due = ecnt + n + 1;
        q_push(id, e);
      end
    end
    ecnt++;
  endtask

  // Observes DUT state left by the previous rising edge.
  task automatic monitor();
    exp_t   e;
    int     cur;
    longint o;
    bit     v, exp_v;
    if (rst_seen) begin
      for (int id = 0; id < ND; id++) begin
        check_val($sformatf("d%0d_rst_valid", id), longint'(valid_of(id)), 0);
        check_val($sformatf("d%0d_rst_output", id), out_of(id), 0);
        last_out[id]   = 0;
        first_edge[id] = -1;
      end
      rst_seen = 1'b0;
      return;
    end
    cur = ecnt - 1;
    for (int id = 0; id < ND; id++) begin
      o = out_of(id);
      v = valid_of(id);
      while (q_len(id) > 0 && q_due(id) < cur) q_pop(id, e);
      exp_v = (q_len(id) > 0) && (q_due(id) == cur);
      check_val($sformatf("d%0d_valid_edge%0d", id, cur), longint'(v), longint'(exp_v));
      if (exp_v) begin
        q_pop(id, e);
        if (v) check_val($sformatf("d%0d_sample_edge%0d", id, cur), o, e.val);
      end
      if (v) begin
        if (first_edge[id] < 0) first_edge[id] = cur;
        last_out[id] = o;
      end else begin
        check_val($sformatf("d%0d_hold_edge%0d", id, cur), o, last_out[id]);
      end
    end
  endtask

  task automatic cycle(input bit p, input bit r);
    @(negedge clk);
    monitor();
    pdm_in = p;
    rst    = r;
    model_step(p, r);
  endtask

  // mode 0: constant 0, 1: constant 1, 2: alternating starting with 1
  task automatic run(input int cycles, input int mode);
    bit p;
    for (int i = 0; i < cycles; i++) begin
      case (mode)
        0:       p = 1'b0;
        1:       p = 1'b1;
        default: p = ~i[0];
      endcase
      cycle(p, 1'b0);
    end
  endtask

  initial begin
    for (int id = 0; id < ND; id++) begin
      last_out[id]   = 0;
      first_edge[id] = -1;
    end
    repeat (3) cycle(1'b0, 1'b1);

    run(40 * 256, 1);
    check_val("d0_first_valid_edge", first_edge[0], 258);
    check_val("d1_first_valid_edge", first_edge[1], 258);
    check_val("d2_first_valid_edge", first_edge[2], 67);
    check_val("d0_const1_fullscale", last_out[0], 65536);
    check_val("d1_const1_signed", last_out[1], 32768);
    check_val("d2_const1_fullscale", last_out[2], 262144);

    run(12 * 256, 0);
    check_val("d0_const0", last_out[0], 0);
    check_val("d1_const0_signed", last_out[1], 229376);
    check_val("d2_const0", last_out[2], 0);

    run(12 * 256, 2);
    check_val("d0_alternating", last_out[0], 32768);
    check_val("d1_alternating_signed", last_out[1], 0);
    check_val("d2_alternating", last_out[2], 131072);

    // Stop on the edge right after a strobe so a token is in flight, then reset.
    do cycle(1'b1, 1'b0); while (ecnt % 256 != 0);
    cycle(1'b1, 1'b1);
    run(12 * 256, 1);
    check_val("d0_restart_first_edge", first_edge[0], 258);
    check_val("d1_restart_first_edge", first_edge[1], 258);
    check_val("d2_restart_first_edge", first_edge[2], 67);
    check_val("d0_restart_const1", last_out[0], 65536);
    check_val("d1_restart_const1", last_out[1], 32768);
    check_val("d2_restart_const1", last_out[2], 262144);

    run(8, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
